// File: rtl/bcd_to_binary.sv
// Three-digit BCD to 8-bit binary converter using reverse double-dabble,
// one shift-and-correct step per clock with a start/busy/done handshake.
module bcd_to_binary (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic       busy,
    output logic       done,
    output logic [7:0] binary,
    output logic       error
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'd9;

    state_t      state_q;
    logic [11:0] bcd_q;
    logic [11:0] bcd_d;
    logic [9:0]  bin_q;
    logic [9:0]  bin_d;
    logic [3:0]  cnt_q;
    logic        invalid_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  binary_q;
    logic        error_q;

    logic        digitsInvalid;
    logic [11:0] bcdShifted;
    logic        overRange;

    assign digitsInvalid = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);

    // A digit's LSB moving into the digit below is worth 5, not 8, so any
    // digit that lands at 8 or above after the shift is pulled down by 3.
    always_comb begin
        bcdShifted = {1'b0, bcd_q[11:1]};
        bin_d      = {bcd_q[0], bin_q[9:1]};
        bcd_d      = bcdShifted;
        for (int i = 0; i < 3; i++) begin
            if (bcdShifted[4*i+3]) begin
                bcd_d[4*i +: 4] = bcdShifted[4*i +: 4] - 4'd3;
            end
        end
    end

    assign overRange = |bin_d[9:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            binary_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= CONV;
                        bcd_q     <= {hundreds, tens, ones};
                        bin_q     <= '0;
                        cnt_q     <= '0;
                        invalid_q <= digitsInvalid;
                        busy_q    <= 1'b1;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // Invalid digits win over range saturation.
                        if (invalid_q) begin
                            binary_q <= 8'h00;
                            error_q  <= 1'b1;
                        end else if (overRange) begin
                            binary_q <= 8'hFF;
                            error_q  <= 1'b1;
                        end else begin
                            binary_q <= bin_d[7:0];
                            error_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign binary = binary_q;
    assign error  = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: stimulus pushes expected results with
// their due cycle, a monitor pops and compares on every done pulse.
module tb_bcd_to_binary;

    typedef struct {
        logic [7:0] bin;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [7:0] binary;
    logic       error;

    int   cyc;
    int   total;
    int   bad;
    exp_t expQ[$];

    bcd_to_binary dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .busy     (busy),
        .done     (done),
        .binary   (binary),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: read at posedge+#1 it equals the number of edges so far.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse start for one edge with the given digits and queue the result.
    task automatic applyStimulus(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                                 input logic [7:0] expBin, input logic expErr);
        exp_t e;
        @(negedge clk);
        hundreds = h;
        tens     = t;
        ones     = o;
        start    = 1'b1;
        @(posedge clk);
        #1;
        e.bin = expBin;
        e.err = expErr;
        e.cyc = cyc + 10;
        expQ.push_back(e);
        start = 1'b0;
        checkOutput("busyAfterAccept", {31'd0, busy}, 32'd1);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("drain", expQ.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every done must match the head of the queue at its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedDone: got done=1 binary=0x%0h, expected no done (cycle %0d)", binary, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("binary", {24'd0, binary}, {24'd0, e.bin});
                    checkOutput("error", {31'd0, error}, {31'd0, e.err});
                    checkOutput("doneCycle", cyc, e.cyc);
                end
            end else if (expQ.size() != 0 && cyc > expQ[0].cyc) begin
                e = expQ.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL missingDone: got no done, expected done at cycle %0d", e.cyc);
            end
        end
    end

    initial begin
        exp_t e;
        int   k;
        total    = 0;
        bad      = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd0;
        repeat (2) @(negedge clk);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetBinary", {24'd0, binary}, 32'd0);
        checkOutput("resetError", {31'd0, error}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
        waitDrain();
        applyStimulus(4'd0, 4'd6, 4'd5, 8'h41, 1'b0);
        waitDrain();
        applyStimulus(4'd2, 4'd5, 4'd5, 8'hFF, 1'b0);
        waitDrain();
        applyStimulus(4'd2, 4'd5, 4'd6, 8'hFF, 1'b1);
        waitDrain();
        applyStimulus(4'd9, 4'd9, 4'd9, 8'hFF, 1'b1);
        waitDrain();
        applyStimulus(4'd1, 4'hA, 4'd3, 8'h00, 1'b1);
        waitDrain();

        // A start at k+4 with other digits must be ignored.
        applyStimulus(4'd1, 4'd2, 4'd3, 8'h7B, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDrain();
        repeat (12) @(negedge clk);

        // Start held high through the done cycle: re-accepted one edge after
        // done, so the second done lands 21 edges after the first accept.
        @(negedge clk);
        hundreds = 4'd0;
        tens     = 4'd6;
        ones     = 4'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        k     = cyc;
        e.bin = 8'h41;
        e.err = 1'b0;
        e.cyc = k + 10;
        expQ.push_back(e);
        repeat (9) @(posedge clk);
        @(negedge clk);
        hundreds = 4'd2;
        tens     = 4'd5;
        ones     = 4'd5;
        @(posedge clk);
        @(posedge clk);
        #1;
        e.bin = 8'hFF;
        e.err = 1'b0;
        e.cyc = k + 21;
        expQ.push_back(e);
        start = 1'b0;
        waitDrain();

        // Reset mid-conversion aborts with no done afterwards.
        applyStimulus(4'd1, 4'd2, 4'd3, 8'h7B, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortBinary", {24'd0, binary}, 32'd0);
        checkOutput("abortError", {31'd0, error}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        applyStimulus(4'd0, 4'd0, 4'd7, 8'h07, 1'b0);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
